// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: framer state encoding, wire constants and the
// byte-wide reflected CRC-32 step used by both the transmit and receive paths.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SFD   = 3'd2,
    ST_DATA  = 3'd3,
    ST_PAD   = 3'd4,
    ST_FCS   = 3'd5,
    ST_IFG   = 3'd6,
    ST_ABORT = 3'd7
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE      = 8'h55;
  localparam logic [7:0]  SFD           = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam int          MIN_BODY_DFLT = 60;
  localparam int          MAX_BODY_DFLT = 1514;
  localparam int          IFG_DFLT      = 12;

  // One byte through the reflected CRC register, data LSB first.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Registered CRC-32 accumulator: reloads on init, folds in one byte per enabled cycle.
module eth_crc32_d8 import eth_pkg::*; (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    o_crc <= CRC_INIT;
    else if (i_init) o_crc <= CRC_INIT;
    else if (i_en)   o_crc <= crc32_d8(o_crc, i_data);
  end

endmodule

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble/SFD, body pass-through, padding, FCS and IFG.
//
// state | meaning
// IDLE  | wire idle, waits for i_valid once the IFG timer has expired
// PRE   | seven preamble bytes
// SFD   | start-of-frame delimiter, CRC and body count reset
// DATA  | source bytes forwarded, one per cycle
// PAD   | zero fill up to the minimum body length
// FCS   | four complemented CRC bytes, LSB byte first
// IFG   | inter-frame gap timer running
// ABORT | error cycle on the wire, then drain source up to i_last
module eth_tx_framer import eth_pkg::*; #(
  parameter int IFG_BYTES = IFG_DFLT,
  parameter int MIN_BODY  = MIN_BODY_DFLT,
  parameter int MAX_BODY  = MAX_BODY_DFLT,
  parameter int PAD_EN    = 1
) (
  input  logic       i_tx_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_tx_en,
  output logic       o_tx_er,
  output logic [7:0] o_tx_d,
  output logic [2:0] o_fsm_state,
  output logic       o_frame_done
);

  localparam logic [10:0] MIN_B    = 11'(MIN_BODY);
  localparam logic [10:0] MAX_B    = 11'(MAX_BODY);
  // IDLE contributes the final gap cycle, so the timer covers one less.
  localparam logic [7:0]  IFG_LOAD = 8'(IFG_BYTES - 1);
  localparam logic [7:0]  IFG_RST  = 8'(IFG_BYTES);

  tx_state_t   state, state_nxt;
  logic [2:0]  seq_cnt;
  logic [10:0] body_cnt;
  logic [10:0] body_cnt_inc;
  logic [7:0]  ifg_cnt;
  logic        abort_last;
  logic        body_inc;
  logic        at_max;
  logic [31:0] crc;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;
  logic        tx_en_nxt, tx_er_nxt, done_nxt;
  logic [7:0]  tx_d_nxt;

  assign body_cnt_inc = body_cnt + 11'd1;
  assign at_max       = (body_cnt == MAX_B);
  assign body_inc     = (state == ST_DATA && i_valid && !at_max) || (state == ST_PAD);
  assign o_ready      = (state == ST_DATA) || (state == ST_ABORT && !abort_last);
  assign o_fsm_state  = state;
  assign fcs          = ~crc;

  always_comb begin
    case (seq_cnt)
      3'd3:    fcs_byte = fcs[7:0];
      3'd2:    fcs_byte = fcs[15:8];
      3'd1:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  eth_crc32_d8 u_crc (
    .i_clk   (i_tx_clk),
    .i_rst_n (i_rst_n),
    .i_init  (state == ST_SFD),
    .i_en    (body_inc),
    .i_data  ((state == ST_PAD) ? 8'h00 : i_data),
    .o_crc   (crc)
  );

  always_ff @(posedge i_tx_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_valid && ifg_cnt == 8'd0) state_nxt = ST_PRE;
      ST_PRE:   if (seq_cnt == 3'd0) state_nxt = ST_SFD;
      ST_SFD:   state_nxt = ST_DATA;
      ST_DATA: begin
        if (at_max || !i_valid) state_nxt = ST_ABORT;
        else if (i_last)
          state_nxt = (PAD_EN != 0 && body_cnt_inc < MIN_B) ? ST_PAD : ST_FCS;
      end
      ST_PAD:   if (body_cnt_inc >= MIN_B) state_nxt = ST_FCS;
      ST_FCS:   if (seq_cnt == 3'd0) state_nxt = ST_IFG;
      ST_IFG:   if (ifg_cnt <= 8'd1) state_nxt = ST_IDLE;
      ST_ABORT: if (abort_last || (i_valid && i_last)) state_nxt = ST_IFG;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered GMII outputs.
  always_comb begin
    tx_en_nxt = 1'b0;
    tx_er_nxt = 1'b0;
    tx_d_nxt  = 8'h00;
    done_nxt  = 1'b0;
    case (state)
      ST_PRE: begin tx_en_nxt = 1'b1; tx_d_nxt = PREAMBLE; end
      ST_SFD: begin tx_en_nxt = 1'b1; tx_d_nxt = SFD; end
      ST_DATA: begin
        tx_en_nxt = 1'b1;
        if (at_max || !i_valid) tx_er_nxt = 1'b1;
        else                    tx_d_nxt  = i_data;
      end
      ST_PAD: tx_en_nxt = 1'b1;
      ST_FCS: begin
        tx_en_nxt = 1'b1;
        tx_d_nxt  = fcs_byte;
        done_nxt  = (seq_cnt == 3'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_tx_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx_en      <= 1'b0;
      o_tx_er      <= 1'b0;
      o_tx_d       <= 8'h00;
      o_frame_done <= 1'b0;
    end else begin
      o_tx_en      <= tx_en_nxt;
      o_tx_er      <= tx_er_nxt;
      o_tx_d       <= tx_d_nxt;
      o_frame_done <= done_nxt;
    end
  end

  // Down-counters reload on state entry and stop at zero.
  always_ff @(posedge i_tx_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seq_cnt    <= 3'd0;
      body_cnt   <= 11'd0;
      ifg_cnt    <= IFG_RST;
      abort_last <= 1'b0;
    end else begin
      if (state != ST_PRE && state_nxt == ST_PRE)      seq_cnt <= 3'd6;
      else if (state != ST_FCS && state_nxt == ST_FCS) seq_cnt <= 3'd3;
      else if (seq_cnt != 3'd0)                        seq_cnt <= seq_cnt - 3'd1;

      if (state == ST_SFD) body_cnt <= 11'd0;
      else if (body_inc)   body_cnt <= body_cnt_inc;

      if (state != ST_IFG && state_nxt == ST_IFG) ifg_cnt <= IFG_LOAD;
      else if (ifg_cnt != 8'd0)                   ifg_cnt <= ifg_cnt - 8'd1;

      if (state == ST_DATA && state_nxt == ST_ABORT) abort_last <= i_valid && i_last;
    end
  end

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

GMII-side Ethernet transmit framer: takes a frame body (DA, SA, type/length, payload) as a byte stream with a valid/ready handshake and drives the wire. Prepends preamble and SFD, pads short frames, appends the FCS and enforces the inter-frame gap. Sits between the switch egress queue and the PHY. It is the transmit counterpart of the receive frame FSM, and its output must be accepted by that receiver when looped back.

## Interface
- `IFG_BYTES`, 12: minimum idle cycles with `o_tx_en` low after the last FCS byte.
- `MIN_BODY`, 60: minimum DA..payload byte count before FCS; shorter bodies are padded with 0x00.
- `MAX_BODY`, 1514: body byte count at which a frame with no `i_last` is aborted.
- `PAD_EN`, 1: 0 disables padding.
- `i_tx_clk`, in, 1: 125 MHz GMII transmit clock.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_data`, in, 8: body byte from the source.
- `i_valid`, in, 1: `i_data` and `i_last` are valid.
- `i_last`, in, 1: current byte is the last body byte.
- `o_ready`, out, 1: byte is accepted when `i_valid && o_ready` at a rising edge.
- `o_tx_en`, out, 1: GMII TX_EN, registered.
- `o_tx_er`, out, 1: GMII TX_ER, registered.
- `o_tx_d`, out, 8: GMII TXD, registered.
- `o_fsm_state`, out, 3: current state encoding.
- `o_frame_done`, out, 1: one-cycle pulse in the cycle the last FCS byte is on `o_tx_d`.

## Operation
- **States** (encoding in brackets):
  - IDLE (0) → PRE when `i_valid` is high.
  - PRE (1): 7 × 0x55 → SFD.
  - SFD (2): 0xD5 → DATA.
  - DATA (3): emits accepted bytes.
    - On `i_last` → PAD if `PAD_EN` and body count < `MIN_BODY`, else FCS.
    - `i_valid` low → ABORT (underrun).
    - Count reaches `MAX_BODY` without `i_last` → ABORT.
  - PAD (4): 0x00 until body count = `MIN_BODY` → FCS.
  - FCS (5): 4 bytes → IFG.
  - IFG (6): `IFG_BYTES` cycles → IDLE.
  - ABORT (7):
    - Drives a single cycle with `o_tx_en`=1, `o_tx_er`=1, `o_tx_d`=0x00.
    - Then keeps `o_ready`=1 and discards source bytes up to and including the one with `i_last`.
    - Then → IFG. If `i_last` was already consumed, it goes → IFG after the error cycle.
- **Ready**: `o_ready` is high only in DATA and ABORT-drain; it is combinational from state.
- **CRC**: CRC-32 in reflected form (poly 0xEDB88320).
  - Initialised to 0xFFFF_FFFF in SFD.
  - Updated on every DATA and PAD byte, LSB-first per byte.
  - FCS = ~crc, sent as bytes [7:0], [15:8], [23:16], [31:24].
- **Body counter**: 11 bits, cleared in SFD, incremented per DATA/PAD byte. It never wraps because ABORT fires at `MAX_BODY`.
- **`o_tx_er`**: 0 everywhere except the ABORT error cycle.
- **Reset**: asynchronous; takes effect mid-frame with no completion of the frame. All outputs go to 0 and `o_fsm_state` = IDLE.
  - After release, the first frame starts no earlier than `IFG_BYTES` cycles later; reset loads the IFG counter.

## Timing
- `i_valid` high in IDLE at edge T: `o_tx_en` rises after T+1.
  - Cycles 1–7 carry 0x55 and cycle 8 carries 0xD5.
  - `o_ready` is high during cycle 8.
- A byte accepted at edge N appears on `o_tx_d` in cycle N+1. Throughput is one byte per cycle with no bubbles.
- Wire frame length = 8 + max(body, `MIN_BODY`) + 4 cycles of `o_tx_en`, followed by ≥ `IFG_BYTES` cycles low.
- `i_valid` held high across back-to-back frames: next preamble starts exactly `IFG_BYTES` cycles after the last FCS byte.
- The source must present the first byte by cycle 8. `i_valid` low in any DATA cycle is an underrun, including the first.

## Structure
- **Package `eth_pkg`**:
  - State enum.
  - Constants: PREAMBLE 0x55, SFD 0xD5, CRC_INIT 0xFFFF_FFFF, CRC_POLY_REFL 0xEDB88320, MIN_BODY/MAX_BODY defaults.
  - Function `crc32_d8`, shared with the receiver.
- **Sub-module `eth_crc32_d8`**: registered CRC, with init, enable and data in and crc out. Instantiated once.

## Test plan
- **Minimum frame**: 60-byte body 0x00..0x3B, `i_valid` continuous.
  - Required: 72 `o_tx_en` cycles; first 8 bytes 55×7, D5.
  - FCS matches the software model.
  - Loopback through the receive FSM reaches CRC state with no error.
- **Padding**: 14-byte body with `i_last` on byte 14.
  - Required: 46 × 0x00 after the body, then FCS over the 60 bytes.
  - `o_ready` low from the cycle after `i_last`.
- **CRC vector**: `PAD_EN`=0, body "123456789" (0x31..0x39).
  - Required: FCS bytes 0x26, 0x39, 0xF4, 0xCB.
  - `o_frame_done` is high with 0xCB.
- **Underrun**: drop `i_valid` for 1 cycle after body byte 20.
  - Required: next wire cycle has `o_tx_er`=1, `o_tx_d`=0x00.
  - Remaining bytes are drained up to `i_last` with no FCS, then 12 idle cycles.
- **Back-to-back**: two 64-byte frames with `i_valid` held high.
  - Required: exactly 12 cycles of `o_tx_en`=0 between them.
- **Reset mid-frame**: assert `i_rst_n`=0 during DATA byte 30.
  - Required: outputs 0 in the same cycle (asynchronous).
  - After release, a new frame transmits correctly with its preamble starting at least 12 cycles later.
